call_stack: RTL and testbench

CALL_STACK -- requirements
Module: call_stack

---
 rtl/call_stack.sv | 95 +++++++++
 tb/tb_call_stack.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// Hardware return-address stack: DEPTH x WIDTH register array with a saturating pointer.
// Optional sticky overflow/underflow detection is enabled by defining CALL_STACK_GUARD_EN.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == PW'(DEPTH));
  assign count   = sp_q;
  assign top_idx = AW'(sp_q - PW'(1));
  assign top     = empty ? '0 : mem_q[top_idx];

  // Push+pop on a non-empty stack replaces the top in place, even when full.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    sp_d   = sp_q;
    wr_en  = 1'b0;
    wr_idx = AW'(sp_q);
    if (flush) begin
      sp_d = '0;
    end else if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      if (!full) begin
        wr_en = 1'b1;
        sp_d  = sp_q + PW'(1);
      end
    end else if (pop) begin
      if (!empty) sp_d = sp_q - PW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // NOTE: the entry array has no reset; entries above sp are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= data_in;
  end

`ifdef CALL_STACK_GUARD_EN
  logic ovf_q, unf_q;
  logic ovf_set, unf_set;

  assign ovf_set = push && !pop && full;
  assign unf_set = pop && !push && empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus random traffic
// compared against a queue-based stack model.
module tb_call_stack;

  localparam int DEPTH = 8;
  localparam int WIDTH = 12;
  localparam int PW    = $clog2(DEPTH) + 1;
`ifdef CALL_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0, pop = 1'b0, flush = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] top;
  logic [PW-1:0]    count;
  logic             empty, full, overflow, underflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               m_ovf, m_unf;

  call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .data_in(data_in), .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit pu, input bit po, input bit fl, input logic [WIDTH-1:0] d);
    if (fl) begin
      model_reset();
    end else if (pu && po && model_q.size() > 0) begin
      model_q[model_q.size()-1] = d;
    end else if (pu) begin
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else if (GUARD) m_ovf = 1'b1;
    end else if (po) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
      else if (GUARD) m_unf = 1'b1;
    end
  endtask

  task automatic check(input string tag);
    logic [WIDTH-1:0] et;
    logic [PW-1:0]    ec;
    et = (model_q.size() == 0) ? '0 : model_q[model_q.size()-1];
    ec = PW'(model_q.size());
    n_assert++;
    assert (top === et) else begin n_fail++; $error("FAIL %s top got %h expected %h", tag, top, et); end
    n_assert++;
    assert (count === ec) else begin n_fail++; $error("FAIL %s count got %0d expected %0d", tag, count, ec); end
    n_assert++;
    assert (empty === (ec == 0)) else begin n_fail++; $error("FAIL %s empty got %b expected %b", tag, empty, ec == 0); end
    n_assert++;
    assert (full === (ec == DEPTH)) else begin n_fail++; $error("FAIL %s full got %b expected %b", tag, full, ec == DEPTH); end
    n_assert++;
    assert (overflow === m_ovf) else begin n_fail++; $error("FAIL %s overflow got %b expected %b", tag, overflow, m_ovf); end
    n_assert++;
    assert (underflow === m_unf) else begin n_fail++; $error("FAIL %s underflow got %b expected %b", tag, underflow, m_unf); end
  endtask

  // Inputs are applied 1 time unit after a rising edge and outputs sampled 1 unit after the next.
  task automatic op(input bit pu, input bit po, input bit fl, input logic [WIDTH-1:0] d, input string tag);
    push = pu; pop = po; flush = fl; data_in = d;
    @(posedge clk);
    model_step(pu, po, fl, d);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    check(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("reset_state");
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Reset-then-push
    op(1, 0, 0, 12'h010, "push1");
    op(1, 0, 0, 12'h020, "push2");
    op(1, 0, 0, 12'h030, "push3");
    op(0, 1, 0, 12'h000, "pop_after3");

    // Fill to full, then overflow attempt
    op(0, 0, 1, 12'h000, "flush_pre_fill");
    for (int i = 1; i <= DEPTH; i++) op(1, 0, 0, WIDTH'(i), "fill");
    op(1, 0, 0, 12'hFFF, "push_when_full");
    op(0, 0, 0, 12'h000, "ovf_sticky");
    op(1, 1, 0, 12'h5A5, "pushpop_full");

    // Pop when empty, then flush clears the flag
    do_reset();
    op(0, 1, 0, 12'h000, "pop_when_empty");
    op(0, 0, 0, 12'h000, "unf_sticky");
    op(0, 0, 1, 12'h000, "flush_clears_unf");

    // Simultaneous push+pop
    op(1, 0, 0, 12'h111, "sim_push111");
    op(1, 0, 0, 12'h222, "sim_push222");
    op(1, 1, 0, 12'h333, "sim_pushpop333");
    op(0, 0, 1, 12'h000, "sim_flush");
    op(1, 1, 0, 12'h444, "sim_pushpop_empty");

    // Async reset between edges with count=5 and push asserted
    op(0, 0, 1, 12'h000, "ar_flush");
    for (int i = 0; i < 5; i++) op(1, 0, 0, WIDTH'(12'h100 + i), "ar_fill");
    push = 1'b1; data_in = 12'h777;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_immediate");
    @(posedge clk); #1;
    check("push_during_reset");
    reset = 1'b1;
    push = 1'b0;
    op(1, 0, 0, 12'h0C3, "push_after_reset");

    // Flush priority over push at count=4
    op(0, 0, 1, 12'h000, "fp_flush");
    for (int i = 0; i < 4; i++) op(1, 0, 0, WIDTH'(12'h200 + i), "fp_fill");
    op(1, 0, 1, 12'h0AB, "flush_with_push");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      bit pu, po, fl;
      r  = int'($urandom_range(0, 99));
      fl = (r < 4);
      pu = (r >= 4 && r < 50) || (r >= 80);
      po = (r >= 50);
      op(pu, po, fl, WIDTH'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
